adc_frame_rx: RTL

Result-frame decoder for the multislope ADC link. It takes the byte stream from a UART receiver and reassembles the 6-byte, MSB-first result frame that the ADC controller transmits after each conversion. It outputs the decoded run-up count, run-up setting, run-down sign and run-down count, plus a derived signed run-up balance. It also detects truncated and malformed frames. It sits on the host/monitor side of the serial link, directly behind a `uart_rx` byte interface.

---
 rtl/adc_frame_pkg.sv | 48 ++++
 rtl/adc_frame_rx_if.sv | 28 ++
 rtl/adc_frame_chk.sv | 17 +
 rtl/adc_frame_rx.sv | 134 +++++++++++++
 4 files changed

// File: rtl/adc_frame_pkg.sv
// rtl/adc_frame_pkg.sv - shared frame layout, constants and helpers for the ADC result link
package adc_frame_pkg;

    localparam int FRAME_BYTES    = 6;
    localparam int RUNUP_CNT_W    = 15;
    localparam int SIGN_W         = 1;
    localparam int RUNUP_SET_W    = 15;
    localparam int RUNDOWN_CNT_W  = 16;
    localparam int BALANCE_W      = RUNUP_CNT_W + 2;

    localparam int RUNUP_SET_MIN  = 199;
    localparam int RUNUP_SET_MAX  = 1999;
    localparam int RUNUP_SET_STEP = 200;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_EMIT
    } rx_state_e;

    typedef struct packed {
        logic                     bit47;
        logic [RUNUP_CNT_W-1:0]   runup_cnt;
        logic                     rundown_sign;
        logic [RUNUP_SET_W-1:0]   runup_set;
        logic [RUNDOWN_CNT_W-1:0] rundown_cnt;
    } adc_frame_t;

    // 2*cnt - (set+1) in 17 bits; zero-extended operands always fit
    function automatic logic signed [BALANCE_W-1:0] calc_balance(
        input logic [RUNUP_CNT_W-1:0] cnt,
        input logic [RUNUP_SET_W-1:0] set
    );
        logic [BALANCE_W-1:0] diff;
        diff = {1'b0, cnt, 1'b0} - {2'b00, set} - 17'd1;
        return $signed(diff);
    endfunction

    function automatic logic runup_set_valid(input logic [RUNUP_SET_W-1:0] set);
        logic hit;
        hit = 1'b0;
        for (int k = RUNUP_SET_MIN; k <= RUNUP_SET_MAX; k += RUNUP_SET_STEP) begin
            if (set == RUNUP_SET_W'(k)) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/adc_frame_rx_if.sv
// rtl/adc_frame_rx_if.sv - byte input and decoded-result bundle of the ADC frame decoder
interface adc_frame_rx_if;
    import adc_frame_pkg::*;

    logic                        byte_vld;
    logic [7:0]                  byte_data;
    logic                        frm_vld;
    logic                        frm_err;
    logic [RUNUP_CNT_W-1:0]      runup_cnt;
    logic                        rundown_sign;
    logic [RUNUP_SET_W-1:0]      runup_set;
    logic [RUNDOWN_CNT_W-1:0]    rundown_cnt;
    logic signed [BALANCE_W-1:0] balance;
    logic [7:0]                  err_cnt;
    logic                        busy;

    modport master (
        output byte_vld, byte_data,
        input  frm_vld, frm_err, runup_cnt, rundown_sign, runup_set,
               rundown_cnt, balance, err_cnt, busy
    );

    modport slave (
        input  byte_vld, byte_data,
        output frm_vld, frm_err, runup_cnt, rundown_sign, runup_set,
               rundown_cnt, balance, err_cnt, busy
    );
endinterface

// File: rtl/adc_frame_chk.sv
// rtl/adc_frame_chk.sv - frame validity check and balance; used only when ADC_FRAME_CHK_EN is defined
module adc_frame_chk
    import adc_frame_pkg::*;
(
    input  adc_frame_t                  frame,
    output logic                        frame_ok,
    output logic signed [BALANCE_W-1:0] balance
);

    logic cnt_ok;

    // run-up count may equal set+1 (full-scale) but never exceed it
    assign cnt_ok   = ({1'b0, frame.runup_cnt} <= ({1'b0, frame.runup_set} + 16'd1));
    assign frame_ok = !frame.bit47 && runup_set_valid(frame.runup_set) && cnt_ok;
    assign balance  = calc_balance(frame.runup_cnt, frame.runup_set);

endmodule

// File: rtl/adc_frame_rx.sv
// rtl/adc_frame_rx.sv - 6-byte ADC result frame decoder behind a UART byte stream
// Optional field checking at EMIT is enabled by defining ADC_FRAME_CHK_EN.
module adc_frame_rx
    import adc_frame_pkg::*;
#(
    parameter int GAP_CYCLES = 4096
) (
    input logic           clk,
    input logic           rst,
    adc_frame_rx_if.slave bus
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
`ifdef ADC_FRAME_CHK_EN
    localparam int BUF_W = (FRAME_BYTES - 1) * 8;
`else
    // bit47 is never needed, so the buffer lets it fall off the top
    localparam int BUF_W = (FRAME_BYTES - 1) * 8 - 1;
`endif

    rx_state_e                   state, state_nxt;
    logic [2:0]                  idx;
    logic [GAP_W-1:0]            gap_cnt;
    logic [BUF_W-1:0]            frame_buf;
    adc_frame_t                  asm_frame;
    logic                        last_byte, gap_expire;
    logic                        chk_ok;
    logic signed [BALANCE_W-1:0] chk_bal;

    logic                        emit_ok_q, tmo_q;
    logic [RUNUP_CNT_W-1:0]      runup_cnt_q;
    logic                        rundown_sign_q;
    logic [RUNUP_SET_W-1:0]      runup_set_q;
    logic [RUNDOWN_CNT_W-1:0]    rundown_cnt_q;
    logic signed [BALANCE_W-1:0] balance_q;
    logic [7:0]                  err_cnt_q;
    logic                        frm_vld_c, frm_err_c;

    assign last_byte  = bus.byte_vld && (state == ST_COLLECT) && (idx == 3'(FRAME_BYTES - 1));
    assign gap_expire = !bus.byte_vld && (state == ST_COLLECT) && (gap_cnt == GAP_W'(GAP_CYCLES - 1));
    assign asm_frame  = adc_frame_t'(48'({frame_buf, bus.byte_data}));

`ifdef ADC_FRAME_CHK_EN
    adc_frame_chk u_chk (
        .frame    (asm_frame),
        .frame_ok (chk_ok),
        .balance  (chk_bal)
    );
`else
    assign chk_ok  = !asm_frame.bit47;
    assign chk_bal = calc_balance(asm_frame.runup_cnt, asm_frame.runup_set);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (bus.byte_vld) state_nxt = ST_COLLECT;
            ST_COLLECT: begin
                if (last_byte)       state_nxt = ST_EMIT;
                else if (gap_expire) state_nxt = ST_IDLE;
            end
            ST_EMIT:    state_nxt = bus.byte_vld ? ST_COLLECT : ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        frm_vld_c = (state == ST_EMIT) && emit_ok_q;
        frm_err_c = ((state == ST_EMIT) && !emit_ok_q) || tmo_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            gap_cnt   <= '0;
            frame_buf <= '0;
        end else begin
            if (bus.byte_vld) begin
                frame_buf <= {frame_buf[BUF_W-9:0], bus.byte_data};
                if (state != ST_COLLECT) idx <= 3'd1;
                else if (last_byte)      idx <= '0;
                else                     idx <= idx + 3'd1;
            end else if (gap_expire) begin
                idx <= '0;
            end
            if (bus.byte_vld || gap_expire || state != ST_COLLECT) gap_cnt <= '0;
            else                                                   gap_cnt <= gap_cnt + 1'b1;
        end
    end

    // fields load on the b5 edge so they are already valid during EMIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            emit_ok_q      <= 1'b0;
            tmo_q          <= 1'b0;
            runup_cnt_q    <= '0;
            rundown_sign_q <= 1'b0;
            runup_set_q    <= '0;
            rundown_cnt_q  <= '0;
            balance_q      <= '0;
            err_cnt_q      <= '0;
        end else begin
            tmo_q <= gap_expire;
            if (last_byte) begin
                emit_ok_q <= chk_ok;
                if (chk_ok) begin
                    runup_cnt_q    <= asm_frame.runup_cnt;
                    rundown_sign_q <= asm_frame.rundown_sign;
                    runup_set_q    <= asm_frame.runup_set;
                    rundown_cnt_q  <= asm_frame.rundown_cnt;
                    balance_q      <= chk_bal;
                end
            end
            if (((last_byte && !chk_ok) || gap_expire) && err_cnt_q != 8'hFF)
                err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.frm_vld      = frm_vld_c;
    assign bus.frm_err      = frm_err_c;
    assign bus.runup_cnt    = runup_cnt_q;
    assign bus.rundown_sign = rundown_sign_q;
    assign bus.runup_set    = runup_set_q;
    assign bus.rundown_cnt  = rundown_cnt_q;
    assign bus.balance      = balance_q;
    assign bus.err_cnt      = err_cnt_q;
    assign bus.busy         = (idx != 3'd0);

endmodule
